// File: rtl/avg_window_seq.sv
// rtl/avg_window_seq.sv - sequencer for the power-of-two windowed accumulator
// Generates per-sample strobes for 2**L windows, counts windows and runs the result valid/ready handshake.
module avg_window_seq #(
   parameter int NMAX = 10,
   parameter int NW   = 16
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic            stop,
   input  logic            mode_cont,
   input  logic [3:0]      log2n,
   input  logic [NW-1:0]   n_windows,
   output logic            acc_en,
   output logic            acc_first,
   output logic            acc_last,
   output logic            res_valid,
   input  logic            res_ready,
   output logic            overrun,
   output logic            busy,
   output logic            done,
   output logic [NW-1:0]   win_cnt,
   output logic [NMAX-1:0] smp_cnt
);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_STOPPING, S_DONE} state_t;

   localparam logic [3:0]    LMAX  = 4'(NMAX);
   localparam logic [NMAX:0] ONE_W = {{NMAX{1'b0}}, 1'b1};

   state_t          state_q, state_d;
   logic [3:0]      lr_q, lr_d;
   logic            mode_q, mode_d;
   logic [NW-1:0]   target_q, target_d;
   logic [NW-1:0]   win_q, win_d;
   logic [NMAX-1:0] smp_q, smp_d;
   logic            en_q, en_d;
   logic            first_q, first_d;
   logic            last_q, last_d;
   logic            valid_q, valid_d;
   logic            ovr_q, ovr_d;
   logic            busy_q, busy_d;
   logic            done_q, done_d;

   logic [NMAX:0]   span_d;
   logic [NMAX-1:0] mask_d;
   logic [NW-1:0]   win_inc;
   logic            final_win;

   // Mask of the last sample index; the extra bit lets a 2**NMAX window wrap to all-ones.
   assign span_d    = (ONE_W << lr_d) - ONE_W;
   assign mask_d    = span_d[NMAX-1:0];
   assign win_inc   = (win_q == '1) ? win_q : win_q + NW'(1);
   assign final_win = ({1'b0, win_q} + (NW+1)'(1)) == {1'b0, target_q};

   always_comb begin
      state_d  = state_q;
      lr_d     = lr_q;
      mode_d   = mode_q;
      target_d = target_q;
      win_d    = win_q;
      smp_d    = smp_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d  = S_RUN;
               lr_d     = (log2n > LMAX) ? LMAX : log2n;
               mode_d   = mode_cont;
               target_d = (n_windows == '0) ? NW'(1) : n_windows;
               smp_d    = '0;
               win_d    = '0;
            end
         end
         S_RUN, S_STOPPING: begin
            if (last_q) begin
               smp_d = '0;
               win_d = win_inc;
               if (state_q == S_STOPPING || stop || (!mode_q && final_win)) begin
                  state_d = S_DONE;
               end
            end else begin
               smp_d = smp_q + NMAX'(1);
               if (stop && state_q == S_RUN) begin
                  state_d = S_STOPPING;
               end
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // The result slot is reloaded on the cycle after acc_last; a same-cycle accept frees it first.
   always_comb begin
      valid_d = (valid_q & ~res_ready) | last_q;
      if (state_q == S_IDLE && start) begin
         ovr_d = 1'b0;
      end else begin
         ovr_d = ovr_q | (last_q & valid_q & ~res_ready);
      end
   end

   always_comb begin
      en_d    = (state_d == S_RUN) || (state_d == S_STOPPING);
      first_d = en_d && (smp_d == '0);
      last_d  = en_d && (smp_d == mask_d);
      busy_d  = (state_d != S_IDLE);
      done_d  = (state_d == S_DONE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         lr_q     <= '0;
         mode_q   <= 1'b0;
         target_q <= '0;
         win_q    <= '0;
         smp_q    <= '0;
         en_q     <= 1'b0;
         first_q  <= 1'b0;
         last_q   <= 1'b0;
         valid_q  <= 1'b0;
         ovr_q    <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         lr_q     <= lr_d;
         mode_q   <= mode_d;
         target_q <= target_d;
         win_q    <= win_d;
         smp_q    <= smp_d;
         en_q     <= en_d;
         first_q  <= first_d;
         last_q   <= last_d;
         valid_q  <= valid_d;
         ovr_q    <= ovr_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
      end
   end

   assign acc_en    = en_q;
   assign acc_first = first_q;
   assign acc_last  = last_q;
   assign res_valid = valid_q;
   assign overrun   = ovr_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign win_cnt   = win_q;
   assign smp_cnt   = smp_q;

endmodule

// File: tb/tb_avg_window_seq.sv
// tb/tb_avg_window_seq.sv - self-checking bench for avg_window_seq
// Table of acquisition runs with a result scoreboard, plus handshake, busy-start and reset sequences.
module tb_avg_window_seq;
   localparam int NMAX = 10;
   localparam int NW   = 16;

   logic            clk = 1'b0;
   logic            rst, start, stop, mode_cont, res_ready;
   logic [3:0]      log2n;
   logic [NW-1:0]   n_windows;
   logic            acc_en, acc_first, acc_last, res_valid, overrun, busy, done;
   logic [NW-1:0]   win_cnt;
   logic [NMAX-1:0] smp_cnt;

   int n_cmp = 0;
   int n_err = 0;
   int unsigned exp_q[$];

   typedef struct {
      bit cont;
      int l;
      int nw;
      int stop_at;
      int exp_run;
      int exp_win;
   } vec_t;

   vec_t tbl[9];

   always #5 clk = ~clk;

   avg_window_seq #(.NMAX(NMAX), .NW(NW)) dut (
      .clk(clk), .rst(rst), .start(start), .stop(stop), .mode_cont(mode_cont),
      .log2n(log2n), .n_windows(n_windows), .acc_en(acc_en), .acc_first(acc_first),
      .acc_last(acc_last), .res_valid(res_valid), .res_ready(res_ready), .overrun(overrun),
      .busy(busy), .done(done), .win_cnt(win_cnt), .smp_cnt(smp_cnt)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_idle(input string name);
      int c;
      c = 0;
      while (busy && c < 2000) begin
         tick();
         c++;
      end
      if (busy) check({name, "_timeout"}, 1, 0);
   endtask

   task automatic kick(input bit cont, input int l, input int nw);
      mode_cont = cont;
      log2n     = 4'(l);
      n_windows = NW'(nw);
      start     = 1'b1;
      tick();
      start     = 1'b0;
   endtask

   task automatic run_row(input vec_t v, input int idx);
      int lr, w, errs, runs, dones, done_at;
      lr = (v.l > NMAX) ? NMAX : v.l;
      w  = 1 << lr;
      exp_q.delete();
      for (int i = 1; i <= v.exp_win; i++) exp_q.push_back(i);
      res_ready = 1'b1;
      kick(v.cont, v.l, v.nw);
      errs = 0; runs = 0; dones = 0; done_at = -1;
      for (int c = 0; c < 2000; c++) begin
         if (res_valid) begin
            if (exp_q.size() == 0) check($sformatf("row%0d_extra_result", idx), 1, 0);
            else check($sformatf("row%0d_result_win", idx), win_cnt, exp_q.pop_front());
         end
         if (acc_en) begin
            runs++;
            if (acc_first !== (c % w == 0) || acc_last !== (c % w == w - 1) ||
                smp_cnt !== NMAX'(c % w) || busy !== 1'b1) errs++;
         end
         if (done) begin
            dones++;
            done_at = c;
         end
         stop = (c == v.stop_at);
         if (!busy) break;
         tick();
      end
      stop = 1'b0;
      check($sformatf("row%0d_strobe_errs", idx), errs, 0);
      check($sformatf("row%0d_run_cycles", idx), runs, v.exp_run);
      check($sformatf("row%0d_done_count", idx), dones, 1);
      check($sformatf("row%0d_done_cycle", idx), done_at, v.exp_run);
      check($sformatf("row%0d_win_cnt", idx), win_cnt, v.exp_win);
      check($sformatf("row%0d_results_left", idx), exp_q.size(), 0);
   endtask

   initial begin
      int runs, dones;
      //        cont  L   nw  stop  run  win
      tbl[0] = '{1'b0, 3,  2,  -1,   16,  2};
      tbl[1] = '{1'b1, 0,  0,   5,    6,  6};
      tbl[2] = '{1'b1, 2,  0,   1,    4,  1};
      tbl[3] = '{1'b0, 15, 1,  -1, 1024,  1};
      tbl[4] = '{1'b0, 2,  0,  -1,    4,  1};
      tbl[5] = '{1'b0, 1,  3,  -1,    6,  3};
      tbl[6] = '{1'b1, 2,  0,   7,    8,  2};
      tbl[7] = '{1'b0, 0,  4,   1,    2,  2};
      tbl[8] = '{1'b1, 3,  0,   9,   16,  2};

      rst = 1'b1; start = 1'b0; stop = 1'b0; mode_cont = 1'b0; res_ready = 1'b0;
      log2n = '0; n_windows = '0;
      tick();
      tick();
      check("reset_flags", {acc_en, acc_first, acc_last, res_valid, overrun, busy, done}, 0);
      check("reset_win_cnt", win_cnt, 0);
      check("reset_smp_cnt", smp_cnt, 0);
      rst = 1'b0;
      tick();

      for (int i = 0; i < 9; i++) run_row(tbl[i], i);

      // Backpressure: results pile up with res_ready low.
      res_ready = 1'b0;
      kick(1'b1, 1, 0);
      tick();
      tick();
      check("bp_valid_first", res_valid, 1);
      check("bp_overrun_first", overrun, 0);
      tick();
      tick();
      check("bp_overrun_second", overrun, 1);
      check("bp_valid_second", res_valid, 1);
      stop = 1'b1;
      tick();
      stop = 1'b0;
      wait_idle("bp_stop");
      check("bp_overrun_idle", overrun, 1);
      kick(1'b1, 1, 0);
      check("bp_restart_overrun", overrun, 0);
      check("bp_restart_valid", res_valid, 1);
      stop = 1'b1;
      tick();
      stop = 1'b0;
      wait_idle("bp_restart_stop");
      res_ready = 1'b1;
      tick();
      tick();
      check("bp_drained", res_valid, 0);

      // Accept arrives on the same cycle as the second result.
      res_ready = 1'b0;
      kick(1'b1, 1, 0);
      tick();
      tick();
      check("coll_valid_first", res_valid, 1);
      tick();
      res_ready = 1'b1;
      tick();
      res_ready = 1'b0;
      check("coll_valid_second", res_valid, 1);
      check("coll_no_overrun", overrun, 0);
      stop = 1'b1;
      tick();
      stop = 1'b0;
      wait_idle("coll_stop");
      res_ready = 1'b1;
      tick();
      tick();

      // start and new settings while busy must not disturb the run.
      kick(1'b0, 2, 2);
      runs = 0;
      for (int c = 0; c < 100; c++) begin
         if (acc_en) runs++;
         if (c == 2) begin
            start = 1'b1; log2n = 4'd0; n_windows = NW'(5); mode_cont = 1'b1;
         end else begin
            start = 1'b0;
         end
         if (!busy) break;
         tick();
      end
      start = 1'b0;
      check("busy_start_runs", runs, 8);
      check("busy_start_win_cnt", win_cnt, 2);

      // Reset in the middle of a window.
      kick(1'b1, 3, 0);
      tick();
      tick();
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("midrst_flags", {acc_en, acc_first, acc_last, res_valid, overrun, busy, done}, 0);
      check("midrst_counters", {win_cnt, smp_cnt}, 0);
      dones = 0;
      for (int c = 0; c < 5; c++) begin
         tick();
         if (done || busy) dones++;
      end
      check("midrst_no_done", dones, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
